// File: rtl/pipe_mult_hs_pkg.sv
// Shared types and helpers for the pipelined handshake multiplier.
// Holds the per-stage slice width and the sign-magnitude conversion
// used when operands enter the pipe.
package pipe_mult_hs_pkg;

  // Widest operand the sign-magnitude helper can handle.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  // Multiplier bits consumed by each accumulate stage.
  function automatic int unsigned slice_bits(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Magnitude of a w-bit operand; two's-complement when is_signed is set.
  // The most negative value maps to 2^(w-1), which still fits in w bits.
  function automatic logic [MAX_W-1:0] sm_mag(input logic [MAX_W-1:0] v,
                                              input int unsigned w,
                                              input logic is_signed);
    logic [MAX_W-1:0] mask;
    logic             sign_bit;
    mask     = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    sign_bit = |(v & (64'd1 << (w - 32'd1)));
    if (is_signed && sign_bit) begin
      return (~v + 64'd1) & mask;
    end else begin
      return v & mask;
    end
  endfunction

endpackage

// File: rtl/pipe_mult_hs_if.sv
// Operand/product handshake bundle for pipe_mult_hs.
// master = stimulus source and result sink, slave = the multiplier.
interface pipe_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] mul_out;

  modport master (
    output in_valid, in_signed, mul_a, mul_b, out_ready,
    input  in_ready, out_valid, mul_out
  );

  modport slave (
    input  in_valid, in_signed, mul_a, mul_b, out_ready,
    output in_ready, out_valid, mul_out
  );
endinterface

// File: rtl/pipe_mult_hs_stage.sv
// One accumulate stage: multiplies |a| by the next K-bit slice of the
// remaining multiplier, shifts into place and adds to the running sum.
// MULT_OPERAND_ISOLATION_EN: when defined, data fields only load for a
// valid incoming record so idle cycles leave the datapath untouched.
module pipe_mult_hs_stage
  import pipe_mult_hs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [4*WIDTH+1:0] rec_i,
  output logic [4*WIDTH+1:0] rec_o
);
  localparam int K     = slice_bits(WIDTH, STAGES);
  localparam int SHIFT = K * IDX;

  typedef struct packed {
    logic               valid;
    logic               neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_rem;
    logic [2*WIDTH-1:0] acc;
  } stage_rec_t;

  stage_rec_t         in_s;
  stage_rec_t         nxt_s;
  stage_rec_t         q_r;
  logic [2*WIDTH-1:0] partial_s;

  assign in_s      = rec_i;
  assign partial_s = (2*WIDTH)'(in_s.a_mag) * (2*WIDTH)'(in_s.b_rem[K-1:0]);

  // Next record: add this stage's shifted partial product, retire K multiplier bits.
  always_comb begin
    nxt_s       = in_s;
    nxt_s.b_rem = in_s.b_rem >> K;
    nxt_s.acc   = in_s.acc + (partial_s << SHIFT);
  end

  // Stage register; everything holds while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (adv) begin
      q_r.valid <= nxt_s.valid;
`ifdef MULT_OPERAND_ISOLATION_EN
      if (nxt_s.valid) begin
        q_r.neg   <= nxt_s.neg;
        q_r.a_mag <= nxt_s.a_mag;
        q_r.b_rem <= nxt_s.b_rem;
        q_r.acc   <= nxt_s.acc;
      end
`else
      q_r.neg   <= nxt_s.neg;
      q_r.a_mag <= nxt_s.a_mag;
      q_r.b_rem <= nxt_s.b_rem;
      q_r.acc   <= nxt_s.acc;
`endif
    end
  end

  assign rec_o = q_r;

endmodule

// File: rtl/pipe_mult_hs.sv
// Parametrised pipelined signed/unsigned multiplier with valid/ready
// handshake. Operands are converted to sign-magnitude on entry, STAGES
// accumulate stages build |a|*|b|, and the sign is applied into mul_out.
// Latency is STAGES cycles; the whole pipe stalls when the sink stalls.
// MULT_OPERAND_ISOLATION_EN: when defined, datapath registers only load
// for valid data (low-toggle build); results at out_valid=1 are the same.
module pipe_mult_hs #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input logic           clk,
  input logic           rst_n,
  pipe_mult_hs_if.slave bus
);
  import pipe_mult_hs_pkg::*;

  localparam int REC_W = 4*WIDTH + 2;

  typedef struct packed {
    logic               valid;
    logic               neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_rem;
    logic [2*WIDTH-1:0] acc;
  } stage_rec_t;

  logic               adv_s;
  logic               signed_s;
  stage_rec_t         head_s;
  stage_rec_t         tail_s;
  logic [REC_W-1:0]   rec_s [STAGES+1];
  logic [2*WIDTH-1:0] result_s;
  logic [2*WIDTH-1:0] mul_out_r;
  logic               out_valid_r;
  logic               unused_s;

  // The pipe moves as a unit whenever the output slot is free or being taken.
  assign adv_s         = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.mul_out   = mul_out_r;

  assign signed_s = (mult_mode_e'(bus.in_signed) == MODE_SIGNED);

  // Entry record: sign-magnitude operands, product sign, empty accumulator.
  always_comb begin
    head_s       = '0;
    head_s.valid = bus.in_valid;
    head_s.neg   = signed_s & (bus.mul_a[WIDTH-1] ^ bus.mul_b[WIDTH-1]);
    head_s.a_mag = WIDTH'(sm_mag(MAX_W'(bus.mul_a), WIDTH, signed_s));
    head_s.b_rem = WIDTH'(sm_mag(MAX_W'(bus.mul_b), WIDTH, signed_s));
  end

  assign rec_s[0] = head_s;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_mult_hs_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (i)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv_s),
      .rec_i (rec_s[i]),
      .rec_o (rec_s[i+1])
    );
  end

  assign tail_s   = stage_rec_t'(rec_s[STAGES]);
  assign result_s = tail_s.neg ? -tail_s.acc : tail_s.acc;
  assign unused_s = ^{tail_s.a_mag, tail_s.b_rem};

  // Output register: signed product and its valid flag, held during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      mul_out_r   <= '0;
    end else if (adv_s) begin
      out_valid_r <= tail_s.valid;
`ifdef MULT_OPERAND_ISOLATION_EN
      if (tail_s.valid) begin
        mul_out_r <= result_s;
      end
`else
      mul_out_r <= result_s;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_mult_hs.sv
// Self-checking bench for pipe_mult_hs: table-driven vectors through a
// scoreboard, hand-written stall/bubble/reset sequences on the 8x4 build,
// and random sweeps on 4x2 and 16x8 builds running alongside.
module tb_pipe_mult_hs;
  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  bit lat_en = 1'b0;
  bit sw_done [2];
  logic [2*W-1:0] cur_exp;

  typedef struct { logic [2*W-1:0] exp; int cyc; } sb_t;
  sb_t q[$];

  typedef struct { logic s; logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] exp; } vec_t;
  vec_t tbl[16];
  int tri_exp[9] = '{9, 16, 21, 24, 25, 24, 21, 16, 9};

  pipe_mult_hs_if #(.WIDTH(W)) bus ();
  pipe_mult_hs #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Scoreboard: push on accept, pop and compare on product handoff.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no product", bus.mul_out);
        end else begin
          sb_t e;
          e = q.pop_front();
          pops++;
          check("product", bus.mul_out, e.exp);
          if (lat_en) check("latency", cyc - e.cyc, S);
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back('{exp: cur_exp, cyc: cyc + 1});
    end
  end

  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    bus.in_valid = 1'b1;
    bus.in_signed = s;
    bus.mul_a = a;
    bus.mul_b = b;
    cur_exp = exp;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 60 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check(name, q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Random sweeps on two other parameter sets, both modes, random backpressure.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 4 : 16;
    localparam int SS = (g == 0) ? 2 : 8;

    pipe_mult_hs_if #(.WIDTH(SW)) sbus ();
    pipe_mult_hs #(.WIDTH(SW), .STAGES(SS)) sdut (.clk(clk), .rst_n(sw_rst_n), .bus(sbus));

    logic [2*SW-1:0] sq[$];
    logic [2*SW-1:0] sexp;

    function automatic logic [2*SW-1:0] sref(input logic s, input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic signed [2*SW-1:0] sa, sb;
      if (s) begin
        sa = {{SW{a[SW-1]}}, a};
        sb = {{SW{b[SW-1]}}, b};
        return sa * sb;
      end
      return {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    endfunction

    // Sweep scoreboard for this parameter set.
    always @(negedge clk) begin
      if (sw_rst_n) begin
        if (sbus.out_valid && sbus.out_ready) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_unexpected_w%0d: got %0h expected no product", SW, sbus.mul_out);
          end else begin
            check($sformatf("sweep_w%0d", SW), 32'(sbus.mul_out), 32'(sq.pop_front()));
          end
        end
        if (sbus.in_valid && sbus.in_ready) sq.push_back(sexp);
      end
    end

    initial begin
      sbus.in_valid = 1'b0;
      sbus.in_signed = 1'b0;
      sbus.mul_a = '0;
      sbus.mul_b = '0;
      sbus.out_ready = 1'b0;
      sexp = '0;
      wait (sw_rst_n);
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) begin
        sbus.in_valid = ($urandom_range(3) != 0);
        sbus.in_signed = 1'($urandom_range(1));
        sbus.mul_a = SW'($urandom);
        sbus.mul_b = SW'($urandom);
        sexp = sref(sbus.in_signed, sbus.mul_a, sbus.mul_b);
        sbus.out_ready = ($urandom_range(3) != 0);
        @(posedge clk); #1;
      end
      sbus.in_valid = 1'b0;
      sbus.out_ready = 1'b1;
      for (int t = 0; t < 100 && sq.size() != 0; t++) begin
        @(posedge clk); #1;
      end
      check($sformatf("sweep_drain_w%0d", SW), sq.size(), 0);
      sw_done[g] = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int seen;
    logic [2*W-1:0] hold;
    logic [3:0] pat;
    logic [2*W-1:0] first_out;
    logic s;
    logic [W-1:0] a, b;

    first_out = '0;
    bus.in_valid = 1'b0;
    bus.in_signed = 1'b0;
    bus.mul_a = '0;
    bus.mul_b = '0;
    bus.out_ready = 1'b1;
    cur_exp = '0;

    for (int i = 0; i < 9; i++) tbl[i] = '{s: 1'b0, a: 8'(i + 1), b: 8'(9 - i), exp: 16'(tri_exp[i])};
    tbl[9]  = '{s: 1'b1, a: 8'h80, b: 8'h80, exp: 16'h4000};
    tbl[10] = '{s: 1'b1, a: 8'h80, b: 8'h7F, exp: 16'hC080};
    tbl[11] = '{s: 1'b1, a: 8'hFF, b: 8'h01, exp: 16'hFFFF};
    tbl[12] = '{s: 1'b0, a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
    tbl[13] = '{s: 1'b1, a: 8'hFD, b: 8'h05, exp: 16'hFFF1};
    tbl[14] = '{s: 1'b0, a: 8'h80, b: 8'hFF, exp: 16'h7F80};
    tbl[15] = '{s: 1'b1, a: 8'h00, b: 8'h80, exp: 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sw_rst_n = 1'b1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mul_out", bus.mul_out, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Table vectors back to back with the sink always ready.
    lat_en = 1'b1;
    p0 = pops;
    for (int i = 0; i < 16; i++) send(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp);
    bus.in_valid = 1'b0;
    wait_drain("table_drain");
    check("table_count", pops - p0, 16);
    lat_en = 1'b0;

    // Backpressure: four products, then hold the sink off for five cycles.
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      s = 1'(i % 2);
      a = W'($urandom);
      b = W'($urandom);
      send(s, a, b, ref_prod(s, a, b));
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 20 && !bus.out_valid; t++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid_rise", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    hold = bus.mul_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid_hold", bus.out_valid, 1);
      check("bp_mul_out_hold", bus.mul_out, hold);
    end
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_count", pops - p0, 4);

    // Bubbles: in_valid 1,0,0,1 should reappear on out_valid STAGES later.
    pat = 4'b1001;
    for (int i = 0; i < S + 4; i++) begin
      if (i < 4) bus.in_valid = pat[i];
      else bus.in_valid = 1'b0;
      bus.in_signed = 1'b0;
      bus.mul_a = W'($urandom);
      bus.mul_b = W'($urandom);
      cur_exp = ref_prod(1'b0, bus.mul_a, bus.mul_b);
      @(posedge clk); #1;
      if (i >= S) begin
        check("bubble_valid", bus.out_valid, pat[i - S]);
`ifdef MULT_OPERAND_ISOLATION_EN
        if (i == S) first_out = bus.mul_out;
        else if (i < S + 3) check("bubble_mul_out_hold", bus.mul_out, first_out);
`endif
      end
    end
    bus.in_valid = 1'b0;
    wait_drain("bubble_drain");

    // Reset with products in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      send(1'b0, a, b, ref_prod(1'b0, a, b));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rf_out_valid_before", bus.out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rf_out_valid_async", bus.out_valid, 0);
    check("rf_mul_out_async", bus.mul_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("rf_no_stale", seen, 0);
    p0 = pops;
    send(1'b0, 8'd15, 8'd15, 16'd225);
    bus.in_valid = 1'b0;
    wait_drain("rf_drain");
    check("rf_new_count", pops - p0, 1);

    for (int t = 0; t < 3000 && !(sw_done[0] && sw_done[1]); t++) begin
      @(posedge clk); #1;
    end
    check("sweep_done", {30'd0, sw_done[1], sw_done[0]}, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
